// File: rtl/control_sequencer.sv
// Microcoded control sequencer: steps T0..T4 and decodes step/opcode/flags
// into the CPU control strobes.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   opcode             - IR[7:4]
//   flag_c, flag_z     - registered flags
//   step, halted       - microstep and halt status
//   HLT..FI            - active-high control strobes
module control_sequencer #(
  parameter bit EARLY_TERMINATE = 1'b1,
  parameter int STEP_W          = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [STEP_W-1:0] step,
  output logic              halted,
  output logic              HLT,
  output logic              MI,
  output logic              RI,
  output logic              RO,
  output logic              IO,
  output logic              II,
  output logic              AI,
  output logic              AO,
  output logic              EO,
  output logic              SU,
  output logic              BI,
  output logic              OI,
  output logic              CE,
  output logic              CO,
  output logic              J,
  output logic              FI
);

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_LDA = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_STA = 4'b0100,
    OP_LDI = 4'b0101,
    OP_JMP = 4'b0110,
    OP_JC  = 4'b0111,
    OP_JZ  = 4'b1000,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } op_e;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctl_t;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  logic [STEP_W-1:0] last;
  ctl_t              c;
  op_e               op;

  assign op = op_e'(opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Final step of each opcode; NOP and unused codes end on an empty T2
  // because the opcode is stale while T1 decides the next step.
  always_comb begin
    last = T2;
    unique case (op)
      OP_LDA, OP_STA: last = T3;
      OP_ADD, OP_SUB: last = T4;
      default:        last = T2;
    endcase
  end

  always_comb begin
    c = '0;
    if (halted_q) begin
      c.hlt = 1'b1;
    end else if (step_q == T0) begin
      c.co = 1'b1;
      c.mi = 1'b1;
    end else if (step_q == T1) begin
      c.ro = 1'b1;
      c.ii = 1'b1;
      c.ce = 1'b1;
    end else if (step_q <= T4) begin
      unique case (op)
        OP_LDA: begin
          if (step_q == T2) begin
            c.io = 1'b1;
            c.mi = 1'b1;
          end else if (step_q == T3) begin
            c.ro = 1'b1;
            c.ai = 1'b1;
          end
        end
        OP_ADD, OP_SUB: begin
          if (step_q == T2) begin
            c.io = 1'b1;
            c.mi = 1'b1;
          end else if (step_q == T3) begin
            c.ro = 1'b1;
            c.bi = 1'b1;
          end else begin
            c.eo = 1'b1;
            c.ai = 1'b1;
            c.fi = 1'b1;
            c.su = (op == OP_SUB);
          end
        end
        OP_STA: begin
          if (step_q == T2) begin
            c.io = 1'b1;
            c.mi = 1'b1;
          end else if (step_q == T3) begin
            c.ao = 1'b1;
            c.ri = 1'b1;
          end
        end
        OP_LDI: begin
          if (step_q == T2) begin
            c.io = 1'b1;
            c.ai = 1'b1;
          end
        end
        OP_JMP, OP_JC, OP_JZ: begin
          if (step_q == T2 &&
              (op == OP_JMP ||
               (op == OP_JC && flag_c) ||
               (op == OP_JZ && flag_z))) begin
            c.io = 1'b1;
            c.j  = 1'b1;
          end
        end
        OP_OUT: begin
          if (step_q == T2) begin
            c.ao = 1'b1;
            c.oi = 1'b1;
          end
        end
        OP_HLT: begin
          if (step_q == T2) c.hlt = 1'b1;
        end
        default: c = '0;
      endcase
    end
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = step_q;
    end else if (step_q > T4) begin
      step_d = T0;
    end else if (step_q == T2 && op == OP_HLT) begin
      // Park on T2 so the halt strobe stays tied to a real step.
      step_d   = T2;
      halted_d = 1'b1;
    end else if (step_q < T2) begin
      step_d = step_q + T1;
    end else if (EARLY_TERMINATE && step_q == last) begin
      step_d = T0;
    end else if (step_q == T4) begin
      step_d = T0;
    end else begin
      step_d = step_q + T1;
    end
  end

  assign step   = step_q;
  assign halted = halted_q;
  assign HLT    = c.hlt;
  assign MI     = c.mi;
  assign RI     = c.ri;
  assign RO     = c.ro;
  assign IO     = c.io;
  assign II     = c.ii;
  assign AI     = c.ai;
  assign AO     = c.ao;
  assign EO     = c.eo;
  assign SU     = c.su;
  assign BI     = c.bi;
  assign OI     = c.oi;
  assign CE     = c.ce;
  assign CO     = c.co;
  assign J      = c.j;
  assign FI     = c.fi;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer, both early-terminate settings.
// Strobes packed as {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI}.
module tb_control_sequencer;

  localparam logic [15:0] M_HLT = 16'h8000;
  localparam logic [15:0] M_MI  = 16'h4000;
  localparam logic [15:0] M_RI  = 16'h2000;
  localparam logic [15:0] M_RO  = 16'h1000;
  localparam logic [15:0] M_IO  = 16'h0800;
  localparam logic [15:0] M_II  = 16'h0400;
  localparam logic [15:0] M_AI  = 16'h0200;
  localparam logic [15:0] M_AO  = 16'h0100;
  localparam logic [15:0] M_EO  = 16'h0080;
  localparam logic [15:0] M_SU  = 16'h0040;
  localparam logic [15:0] M_BI  = 16'h0020;
  localparam logic [15:0] M_OI  = 16'h0010;
  localparam logic [15:0] M_CE  = 16'h0008;
  localparam logic [15:0] M_CO  = 16'h0004;
  localparam logic [15:0] M_J   = 16'h0002;
  localparam logic [15:0] M_FI  = 16'h0001;
  localparam logic [15:0] BUS   = M_CO | M_RO | M_IO | M_AO | M_EO;
  localparam logic [15:0] F0    = M_CO | M_MI;
  localparam logic [15:0] F1    = M_RO | M_II | M_CE;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [3:0]  op0, op1;
  logic        fc, fz;
  logic [2:0]  st0, st1;
  logic        h0, h1;
  logic [15:0] c0, c1;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  control_sequencer #(.EARLY_TERMINATE(1'b1), .STEP_W(3)) dut0 (
    .clk(clk), .rst(rst0), .opcode(op0),
    .flag_c(fc), .flag_z(fz),
    .step(st0), .halted(h0),
    .HLT(c0[15]), .MI(c0[14]), .RI(c0[13]), .RO(c0[12]),
    .IO(c0[11]), .II(c0[10]), .AI(c0[9]), .AO(c0[8]),
    .EO(c0[7]), .SU(c0[6]), .BI(c0[5]), .OI(c0[4]),
    .CE(c0[3]), .CO(c0[2]), .J(c0[1]), .FI(c0[0])
  );

  control_sequencer #(.EARLY_TERMINATE(1'b0), .STEP_W(3)) dut1 (
    .clk(clk), .rst(rst1), .opcode(op1),
    .flag_c(fc), .flag_z(fz),
    .step(st1), .halted(h1),
    .HLT(c1[15]), .MI(c1[14]), .RI(c1[13]), .RO(c1[12]),
    .IO(c1[11]), .II(c1[10]), .AI(c1[9]), .AO(c1[8]),
    .EO(c1[7]), .SU(c1[6]), .BI(c1[5]), .OI(c1[4]),
    .CE(c1[3]), .CO(c1[2]), .J(c1[1]), .FI(c1[0])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc0(input string tag, input int s,
                      input logic [15:0] c, input logic h);
    chk({tag, ".step"}, 32'(st0), 32'(s));
    chk({tag, ".ctl"}, 32'(c0), 32'(c));
    chk({tag, ".halt"}, 32'(h0), 32'(h));
  endtask

  task automatic cyc1(input string tag, input int s,
                      input logic [15:0] c);
    chk({tag, ".step"}, 32'(st1), 32'(s));
    chk({tag, ".ctl"}, 32'(c1), 32'(c));
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    op0  = 4'b0010;
    op1  = 4'b0000;
    fc   = 1'b0;
    fz   = 1'b0;
    tick();
    tick();
    rst0 = 1'b0;
    cyc0("rst", 0, F0, 1'b0);
    tick();
    cyc0("add_t1", 1, F1, 1'b0);
    tick();
    cyc0("add_t2", 2, M_IO | M_MI, 1'b0);
    tick();
    cyc0("add_t3", 3, M_RO | M_BI, 1'b0);
    rst0 = 1'b1;
    tick();
    tick();
    rst0 = 1'b0;
    cyc0("rst_mid", 0, F0, 1'b0);

    op0 = 4'b0001;
    tick();
    cyc0("lda_t1", 1, F1, 1'b0);
    tick();
    cyc0("lda_t2", 2, M_IO | M_MI, 1'b0);
    tick();
    cyc0("lda_t3", 3, M_RO | M_AI, 1'b0);
    tick();
    cyc0("lda_end", 0, F0, 1'b0);

    op0 = 4'b0011;
    tick();
    tick();
    cyc0("sub_t2", 2, M_IO | M_MI, 1'b0);
    tick();
    cyc0("sub_t3", 3, M_RO | M_BI, 1'b0);
    tick();
    cyc0("sub_t4", 4, M_EO | M_AI | M_SU | M_FI, 1'b0);
    tick();
    cyc0("sub_end", 0, F0, 1'b0);

    op0 = 4'b0100;
    tick();
    tick();
    cyc0("sta_t2", 2, M_IO | M_MI, 1'b0);
    tick();
    cyc0("sta_t3", 3, M_AO | M_RI, 1'b0);
    tick();
    cyc0("sta_end", 0, F0, 1'b0);

    op0 = 4'b0111;
    fc  = 1'b0;
    tick();
    tick();
    cyc0("jc0_t2", 2, 16'h0000, 1'b0);
    tick();
    cyc0("jc0_end", 0, F0, 1'b0);
    fc = 1'b1;
    tick();
    tick();
    cyc0("jc1_t2", 2, M_IO | M_J, 1'b0);
    tick();
    cyc0("jc1_end", 0, F0, 1'b0);

    op0 = 4'b1000;
    fc  = 1'b0;
    fz  = 1'b1;
    tick();
    tick();
    cyc0("jz1_t2", 2, M_IO | M_J, 1'b0);
    tick();
    fz = 1'b0;
    tick();
    tick();
    cyc0("jz0_t2", 2, 16'h0000, 1'b0);
    tick();
    cyc0("jz0_end", 0, F0, 1'b0);

    op0 = 4'b1110;
    tick();
    tick();
    cyc0("out_t2", 2, M_AO | M_OI, 1'b0);
    tick();
    op0 = 4'b0110;
    tick();
    tick();
    cyc0("jmp_t2", 2, M_IO | M_J, 1'b0);
    tick();
    op0 = 4'b0101;
    tick();
    tick();
    cyc0("ldi_t2", 2, M_IO | M_AI, 1'b0);
    tick();
    cyc0("ldi_end", 0, F0, 1'b0);

    op0 = 4'b1011;
    tick();
    cyc0("und_t1", 1, F1, 1'b0);
    tick();
    cyc0("und_t2", 2, 16'h0000, 1'b0);
    tick();
    cyc0("und_end", 0, F0, 1'b0);
    op0 = 4'b0000;
    tick();
    tick();
    cyc0("nop_t2", 2, 16'h0000, 1'b0);
    tick();
    cyc0("nop_end", 0, F0, 1'b0);

    op0 = 4'b1111;
    tick();
    tick();
    cyc0("hlt_t2", 2, M_HLT, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      cyc0("halted", 2, M_HLT, 1'b1);
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    cyc0("hlt_rst", 0, F0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      op0 = 4'($urandom_range(0, 14));
      fc  = 1'($urandom);
      fz  = 1'($urandom);
      #1;
      chk("bus_onehot",
          32'($countones(c0 & BUS) <= 1), 32'd1);
      chk("step_max", 32'(st0 <= 3'd4), 32'd1);
      tick();
    end

    op1  = 4'b0101;
    rst1 = 1'b0;
    cyc1("et0_ldi_t0", 0, F0);
    tick();
    cyc1("et0_ldi_t1", 1, F1);
    tick();
    cyc1("et0_ldi_t2", 2, M_IO | M_AI);
    tick();
    cyc1("et0_ldi_t3", 3, 16'h0000);
    tick();
    cyc1("et0_ldi_t4", 4, 16'h0000);
    tick();
    cyc1("et0_ldi_end", 0, F0);
    op1 = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    cyc1("et0_add_t4", 4, M_EO | M_AI | M_FI);
    tick();
    cyc1("et0_add_end", 0, F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
